// File: rtl/xain_pkg.sv
// Shared types and constants for the bridge-to-ioctl byte streamer.
package xain_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } ser_state_t;

    localparam int IOCTL_ADDR_W   = 27;
    localparam int WR_GAP_DEFAULT = 3;

endpackage

// File: rtl/bridge_byte_streamer_if.sv
// Byte-wide ioctl download stream between the streamer (master) and rom_loader (slave).
interface bridge_byte_streamer_if;
    import xain_pkg::*;

    logic                    ioctl_downl;
    logic                    ioctl_wr;
    logic [7:0]              ioctl_data;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic                    ioctl_wait;

    modport master (
        output ioctl_downl,
        output ioctl_wr,
        output ioctl_data,
        output ioctl_addr,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_downl,
        input  ioctl_wr,
        input  ioctl_data,
        input  ioctl_addr,
        output ioctl_wait
    );

endinterface

// File: rtl/bridge_byte_streamer_fifo.sv
// Single-clock word FIFO with synchronous flush and first-word-fall-through read.
module sync_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bridge_byte_streamer.sv
// Buffers 32-bit bridge data-slot words and serializes them MSB-first onto the ioctl byte stream.
module bridge_byte_streamer
    import xain_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_GAP      = WR_GAP_DEFAULT,
    parameter int ALMOST_FULL = FIFO_DEPTH - 2
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    dl_start,
    input  logic [IOCTL_ADDR_W-1:0] dl_bytes,
    input  logic                    bridge_wr,
    input  logic [31:0]             bridge_wr_data,
    output logic                    fifo_afull,
    output logic                    overflow,
    bridge_byte_streamer_if.master  io
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = $clog2(WR_GAP + 1);

    ser_state_t              state, state_d;
    logic [31:0]             shift;
    logic [2:0]              byte_sel;
    logic [GAP_W-1:0]        gap_cnt;
    logic [IOCTL_ADDR_W-1:0] remaining;
    logic [IOCTL_ADDR_W-1:0] byte_idx;

    logic             fifo_flush;
    logic             fifo_wr;
    logic             fifo_pop;
    logic [31:0]      fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             load;
    logic             issue;
    logic             gap_ready;
    logic             gap_last;

    assign fifo_flush = dl_start || (state == S_DONE);
    assign fifo_wr    = bridge_wr && io.ioctl_downl;
    assign fifo_afull = (fifo_count >= CNT_W'(ALMOST_FULL));
    assign gap_ready  = (gap_cnt >= GAP_W'(WR_GAP));
    assign gap_last   = (gap_cnt == GAP_W'(WR_GAP - 1));

    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (reset_n),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (bridge_wr_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d  = state;
        fifo_pop = 1'b0;
        load     = 1'b0;
        issue    = 1'b0;
        case (state)
            S_IDLE: begin
                if (io.ioctl_downl && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (gap_ready && !io.ioctl_wait) begin
                    issue   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    if (remaining == '0) begin
                        state_d = S_DONE;
                    end else if (byte_sel == 3'd4) begin
                        // Chain straight into the next word to keep peak throughput.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            load     = 1'b1;
                            state_d  = S_ISSUE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A new download aborts whatever is in flight.
        if (dl_start) begin
            fifo_pop = 1'b0;
            load     = 1'b0;
            issue    = 1'b0;
            state_d  = (dl_bytes == '0) ? S_DONE : S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            io.ioctl_downl <= 1'b0;
            io.ioctl_wr    <= 1'b0;
            io.ioctl_data  <= '0;
            io.ioctl_addr  <= '0;
            overflow       <= 1'b0;
            remaining      <= '0;
            byte_idx       <= '0;
            byte_sel       <= '0;
            gap_cnt        <= '0;
        end else begin
            io.ioctl_wr <= issue;
            if (dl_start) begin
                io.ioctl_downl <= 1'b1;
                io.ioctl_addr  <= '0;
                overflow       <= 1'b0;
                remaining      <= dl_bytes;
                byte_idx       <= '0;
                byte_sel       <= '0;
                gap_cnt        <= GAP_W'(WR_GAP);
            end else begin
                if (state == S_DONE) io.ioctl_downl <= 1'b0;
                if (bridge_wr && io.ioctl_downl && fifo_full) overflow <= 1'b1;
                if (load) byte_sel <= '0;
                if (issue) begin
                    io.ioctl_data <= shift[31:24];
                    io.ioctl_addr <= byte_idx;
                    byte_idx      <= byte_idx + 1'b1;
                    remaining     <= remaining - 1'b1;
                    byte_sel      <= byte_sel + 1'b1;
                    gap_cnt       <= '0;
                end else if (!gap_ready) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (load)       shift <= fifo_rd_data;
        else if (issue) shift <= {shift[23:0], 8'h00};
    end

endmodule

// File: tb/tb_bridge_byte_streamer.sv
// Randomized and directed bench for bridge_byte_streamer with a byte-queue reference model.
module tb_bridge_byte_streamer;
    import xain_pkg::*;

    localparam int DEPTH  = 16;
    localparam int GAP    = 3;
    localparam int AFULL  = DEPTH - 2;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        dl_start = 1'b0;
    logic [26:0] dl_bytes = '0;
    logic        bridge_wr = 1'b0;
    logic [31:0] bridge_wr_data = '0;
    logic        drop_wr = 1'b0;
    logic        fifo_afull;
    logic        overflow;
    bit          wait_rand = 1'b0;
    bit          wait_force = 1'b0;

    bridge_byte_streamer_if io();

    bridge_byte_streamer #(
        .FIFO_DEPTH  (DEPTH),
        .WR_GAP      (GAP),
        .ALMOST_FULL (AFULL)
    ) dut (
        .sys_clk        (sys_clk),
        .reset_n        (reset_n),
        .dl_start       (dl_start),
        .dl_bytes       (dl_bytes),
        .bridge_wr      (bridge_wr),
        .bridge_wr_data (bridge_wr_data),
        .fifo_afull     (fifo_afull),
        .overflow       (overflow),
        .io             (io)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: bytes owed to the stream, derived from accepted words and dl_bytes.
    logic [7:0]  exp_q[$];
    logic [7:0]  seen_data[$];
    int          seen_addr[$];
    int          seen_cyc[$];
    int          total = 0, budget = 0, strobes = 0, exp_addr = 0;
    int          phase = 0, tail_k = 0, last_strobe = -100, cyc = 0;
    logic [7:0]  last_data = '0;
    int          last_addr = 0;
    bit          ovf_m = 1'b0, dl_m = 1'b0;
    bit          s_start = 0, s_wr = 0, s_drop = 0, s_wait = 0;
    logic [26:0] s_bytes = '0;
    logic [31:0] s_data = '0;

    always @(negedge sys_clk) begin
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            phase = 0; strobes = 0; total = 0; budget = 0; exp_addr = 0;
            last_data = '0; last_addr = 0; ovf_m = 0; dl_m = 0; last_strobe = -100;
            check("reset_downl", 64'(io.ioctl_downl), 0);
            check("reset_wr", 64'(io.ioctl_wr), 0);
            check("reset_addr", 64'(io.ioctl_addr), 0);
            check("reset_overflow", 64'(overflow), 0);
            s_start = 0; s_wr = 0; s_drop = 0; s_wait = 0;
        end else begin
            if (s_start) begin
                exp_q.delete(); seen_data.delete(); seen_addr.delete(); seen_cyc.delete();
                total = int'(s_bytes); budget = total; strobes = 0; exp_addr = 0;
                last_addr = 0; ovf_m = 0; last_strobe = -100;
                if (total == 0) begin phase = 2; tail_k = GAP - 1; end
                else phase = 1;
            end else if (s_wr && dl_m) begin
                if (s_drop) ovf_m = 1;
                else for (int b = 0; b < 4; b++)
                    if (budget > 0) begin exp_q.push_back(s_data[31-8*b -: 8]); budget--; end
            end
            if (io.ioctl_wr) begin
                check("wr_outside_download", 64'(io.ioctl_downl), 1);
                check("wr_while_wait", 64'(s_wait), 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_strobe actual=%0h required=none", io.ioctl_data);
                end else begin
                    check("byte_data", 64'(io.ioctl_data), 64'(exp_q[0]));
                    check("byte_addr", 64'(io.ioctl_addr), 64'(exp_addr));
                    last_data = exp_q.pop_front();
                end
                if (last_strobe >= 0) check("strobe_spacing", 64'(cyc - last_strobe >= GAP + 1), 1);
                seen_data.push_back(io.ioctl_data); seen_addr.push_back(int'(io.ioctl_addr));
                seen_cyc.push_back(cyc);
                last_strobe = cyc; last_addr = exp_addr; exp_addr++; strobes++;
                if (phase == 1 && strobes == total) begin phase = 2; tail_k = 0; end
            end else begin
                check("data_stable", 64'(io.ioctl_data), 64'(last_data));
                check("addr_stable", 64'(io.ioctl_addr), 64'(last_addr));
                if (phase == 2) tail_k++;
            end
            dl_m = (phase == 1) || (phase == 2 && tail_k <= GAP);
            check("downl", 64'(io.ioctl_downl), 64'(dl_m));
            check("overflow", 64'(overflow), 64'(ovf_m));
            if (phase == 2 && tail_k > GAP) phase = 0;
            s_start = dl_start; s_bytes = dl_bytes; s_wr = bridge_wr;
            s_data = bridge_wr_data; s_drop = drop_wr; s_wait = io.ioctl_wait;
        end
    end

    initial begin
        io.ioctl_wait = 1'b0;
        forever begin
            @(posedge sys_clk); #2;
            io.ioctl_wait = wait_rand ? ($urandom_range(0, 2) == 0) : wait_force;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic start_dl(input int n);
        dl_start = 1'b1; dl_bytes = 27'(n);
        tick(1);
        dl_start = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] d, input bit drop);
        bridge_wr = 1'b1; bridge_wr_data = d; drop_wr = drop;
        tick(1);
        bridge_wr = 1'b0; drop_wr = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit, input int n_bytes);
        int n = 0;
        while (io.ioctl_downl && n < limit) begin tick(1); n++; end
        if (io.ioctl_downl) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=<%0d", name, n, limit);
        end
        tick(2);
        check({name, "_strobes"}, 64'(strobes), 64'(n_bytes));
        check({name, "_queue_drained"}, 64'(exp_q.size()), 0);
    endtask

    task automatic wait_strobes(input int target, input int limit);
        int n = 0;
        while (strobes < target && n < limit) begin tick(1); n++; end
        check("strobe_reached", 64'(strobes >= target), 1);
    endtask

    logic [7:0] lit8[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] lit4[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        #1 reset_n = 1'b0;
        #30;
        check("rst_data", 64'(io.ioctl_data), 0);
        check("rst_afull", 64'(fifo_afull), 0);
        @(negedge sys_clk); #2 reset_n = 1'b1;
        tick(2);
        check("post_reset_downl", 64'(io.ioctl_downl), 0);

        // Eight bytes from two words at full rate.
        start_dl(8);
        write_word(32'h11223344, 0);
        write_word(32'h55667788, 0);
        wait_done("t8", 200, 8);
        check("t8_count", 64'(seen_data.size()), 8);
        for (int i = 0; i < 8 && i < seen_data.size(); i++) begin
            check("t8_lit_data", 64'(seen_data[i]), 64'(lit8[i]));
            check("t8_lit_addr", 64'(seen_addr[i]), 64'(i));
            if (i > 0) check("t8_spacing_exact", 64'(seen_cyc[i] - seen_cyc[i-1]), GAP + 1);
        end

        // Partial last word: only six bytes emitted.
        start_dl(6);
        write_word(32'h11223344, 0);
        write_word(32'h55667788, 0);
        wait_done("t6", 200, 6);
        check("t6_last_byte", 64'(seen_data[seen_data.size()-1]), 8'h66);
        check("t6_afull_clear", 64'(fifo_afull), 0);

        // Back-pressure hold after the second strobe.
        start_dl(8);
        write_word(32'h11223344, 0);
        write_word(32'h55667788, 0);
        wait_strobes(2, 100);
        wait_force = 1'b1;
        tick(20);
        check("hold_no_strobe", 64'(strobes), 2);
        wait_force = 1'b0;
        begin
            int n = 0;
            while (strobes < 3 && n < 10) begin tick(1); n++; end
            check("wait_release_latency", 64'(n <= GAP + 1), 1);
        end
        wait_done("hold", 200, 8);
        for (int i = 0; i < 8 && i < seen_data.size(); i++)
            check("hold_lit_data", 64'(seen_data[i]), 64'(lit8[i]));

        // Zero-length download.
        start_dl(0);
        begin
            int c = 0;
            repeat (5) begin if (io.ioctl_downl) c++; tick(1); end
            check("zero_downl_cycles", 64'(c), 1);
            check("zero_strobes", 64'(strobes), 0);
        end

        // Burst into a stalled serializer until the FIFO overflows.
        wait_force = 1'b1;
        start_dl(4 * (DEPTH + 1));
        write_word($urandom, 0);
        tick(4);
        for (int i = 0; i <= DEPTH; i++) begin
            bridge_wr = 1'b1; bridge_wr_data = $urandom; drop_wr = (i == DEPTH);
            tick(1);
            check("burst_afull", 64'(fifo_afull), 64'(i + 1 >= AFULL));
            check("burst_overflow", 64'(overflow), 64'(i == DEPTH));
        end
        bridge_wr = 1'b0; drop_wr = 1'b0;
        wait_force = 1'b0;
        wait_done("burst", 1000, 4 * (DEPTH + 1));

        // Randomized downloads with random back-pressure and write spacing.
        wait_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int n, words;
            n = $urandom_range(1, 48);
            words = (n + 3) / 4 + $urandom_range(0, 1);
            start_dl(n);
            for (int w = 0; w < words; w++) begin
                tick($urandom_range(0, 5));
                write_word($urandom, 0);
            end
            wait_done("rand", 3000, n);
        end
        wait_rand = 1'b0;
        tick(3);

        // Asynchronous reset mid-stream, then a clean restart.
        start_dl(8);
        write_word(32'h11223344, 0);
        write_word(32'h55667788, 0);
        wait_strobes(3, 100);
        @(negedge sys_clk); #2 reset_n = 1'b0;
        #1;
        check("async_rst_downl", 64'(io.ioctl_downl), 0);
        check("async_rst_wr", 64'(io.ioctl_wr), 0);
        check("async_rst_data", 64'(io.ioctl_data), 0);
        check("async_rst_addr", 64'(io.ioctl_addr), 0);
        tick(3);
        @(negedge sys_clk); #2 reset_n = 1'b1;
        tick(1);
        start_dl(4);
        write_word(32'hA1B2C3D4, 0);
        wait_done("after_rst", 200, 4);
        check("after_rst_count", 64'(seen_data.size()), 4);
        for (int i = 0; i < 4 && i < seen_data.size(); i++) begin
            check("after_rst_data", 64'(seen_data[i]), 64'(lit4[i]));
            check("after_rst_addr", 64'(seen_addr[i]), 64'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bridge_byte_streamer.md
Name: bridge_byte_streamer

Overview:
- Upstream feeder for the ROM loader: accepts 32-bit APF bridge data-slot writes and buffers them in a word FIFO.
- Serializes the buffered words into the byte-wide ioctl stream (ioctl_downl / ioctl_wr / ioctl_data).
- Honours ioctl_wait back-pressure, so SDRAM write latency never drops bridge data.
- Sits between the APF bridge/data-slot logic and rom_loader, in the sys_clk domain.

Parameters:
- FIFO_DEPTH, 16, words of 32-bit buffering; power of two, ≥4.
- WR_GAP, 3, minimum sys_clk cycles ioctl_wr stays low between strobes; must be ≥2.
- ALMOST_FULL, FIFO_DEPTH-2, occupancy at which fifo_afull asserts.

Ports:
- sys_clk  in  1  system clock; all logic is in this domain.
- reset_n  in  1  asynchronous active-low reset.
- dl_start  in  1  one-cycle pulse; a download begins.
- dl_bytes  in  27  total payload bytes; sampled on dl_start.
- bridge_wr  in  1  one-cycle word write strobe.
- bridge_wr_data  in  32  word data; big-endian byte order, bits [31:24] sent first.
- fifo_afull  out  1  occupancy ≥ ALMOST_FULL; advisory to the bridge side.
- overflow  out  1  sticky; a bridge_wr arrived while the FIFO was full.
- ioctl_downl  out  1  download in progress.
- ioctl_wr  out  1  one-cycle byte strobe; the consumer captures on the rising edge.
- ioctl_data  out  8  byte value, stable from the strobe until the next strobe.
- ioctl_addr  out  27  byte index of the current ioctl_data.
- ioctl_wait  in  1  consumer busy; no new strobe may be issued while high.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; byte counter 0.
- Reset is legal mid-download: it aborts the transfer immediately, drops ioctl_downl, and flushes the FIFO.
- dl_start:
  - flushes the FIFO, clears overflow and ioctl_addr, and latches dl_bytes into remaining.
  - sets ioctl_downl the next cycle.
  - if dl_bytes == 0, ioctl_downl pulses for exactly 1 cycle and no strobes occur.
- FIFO:
  - a write is accepted on bridge_wr when not full; when full, the word is discarded and overflow sets.
  - a simultaneous write and pop in the same cycle is legal and leaves occupancy unchanged.
  - bridge_wr while ioctl_downl == 0 is ignored.
- Serializer FSM:
  - IDLE: when ioctl_downl is high and the FIFO is non-empty, pop a word into the shift register, set byte_sel = 0, go to ISSUE.
  - ISSUE: wait for the gap counter ≥ WR_GAP and ioctl_wait == 0. Then drive ioctl_data = shift[31:24] and ioctl_wr = 1 for one cycle, shift left by 8, increment byte_sel, decrement remaining, clear the gap counter, go to GAP.
  - GAP: ioctl_wr = 0 and the gap counter increments.
    - When the counter reaches WR_GAP: if remaining == 0, go to DONE.
    - Otherwise, if byte_sel == 4, go to IDLE (or pop the next word directly when the FIFO is non-empty); else go to ISSUE.
  - DONE: deassert ioctl_downl the next cycle, flush leftover FIFO words (padding past dl_bytes), go to IDLE.
- ioctl_addr updates in the same cycle as ioctl_wr and equals the byte index from 0.
- ioctl_wait is sampled only in ISSUE. WR_GAP ≥ 2 guarantees the consumer's registered wait response (1 cycle after the rising edge) is visible before the next strobe.
- The gap counter saturates at WR_GAP; it starts at WR_GAP after dl_start so the first strobe is not delayed.
- Peak throughput: 1 byte per WR_GAP+1 cycles.
- Partial last word: only the remaining bytes are emitted, MSB first; trailing bytes are dropped.
- A new dl_start while active behaves as an abort plus restart.

Decomposition:
- Package xain_pkg holds:
  - the serializer state enum (IDLE, ISSUE, GAP, DONE);
  - constant IOCTL_ADDR_W = 27;
  - the default WR_GAP.
- One sub-module, sync_word_fifo: a single-clock FIFO with parameter DEPTH, flush input, full/empty/count outputs, and first-word-fall-through read.

Test Plan:
- dl_start with dl_bytes = 8, then two writes 0x11223344 and 0x55667788 → ioctl_data sequence 11,22,33,44,55,66,77,88; ioctl_addr 0..7; strobes exactly WR_GAP+1 cycles apart; ioctl_downl falls after the last strobe.
- dl_bytes = 6 with the same two words → 6 strobes (11..66); bytes 77 and 88 are dropped; FIFO is empty at the end.
- Hold ioctl_wait high for 20 cycles after the 2nd strobe → no strobe during the hold; the 3rd strobe occurs within WR_GAP+1 cycles of wait falling; no byte is lost or duplicated.
- Burst FIFO_DEPTH+1 writes back-to-back while ioctl_wait is held high → fifo_afull asserts at ALMOST_FULL; overflow sets on the last write; the first FIFO_DEPTH words are emitted intact.
- dl_bytes = 0 → ioctl_downl is a 1-cycle pulse; zero ioctl_wr strobes.
- Assert reset_n low mid-stream after byte 3 → all outputs are 0 asynchronously. A following dl_start with 4 bytes emits from ioctl_addr 0 with no stale data.
